// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end (sequencer and control unit).
// Holds the externally visible state encoding and default bus widths.
package cpu_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 12;
  localparam int CNT_W_DEF  = 16;

  // Encoding seen on present_state and decoded by the control unit.
  typedef enum logic [1:0] {
    ST_LOAD    = 2'b00,
    ST_FETCH   = 2'b01,
    ST_DECODE  = 2'b10,
    ST_EXECUTE = 2'b11
  } cpu_state_e;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Program-load stream between a loader (master) and the sequencer (slave).
// A word moves on every cycle where load_valid and load_ready are both high.
interface cpu_sequencer_if import cpu_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;

  modport master (output load_valid, output load_data, output load_last, input load_ready);
  modport slave  (input load_valid, input load_data, input load_last, output load_ready);
endinterface

// File: rtl/cpu_sequencer.sv
// CPU sequencer: loads the program over a valid/ready stream into program
// memory, then cycles FETCH -> DECODE -> EXECUTE, with halt parking and a
// retired-instruction counter.
// Optional build macro SINGLE_STEP_EN adds a 'step' input that runs exactly
// one instruction out of the parked (halted) state.
module cpu_sequencer import cpu_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_sequencer_if.slave    ld,
  input  logic              halt,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [1:0]        present_state,
  output logic [ADDR_W-1:0] pmem_load_addr,
  output logic [DATA_W-1:0] pmem_load_data,
  output logic              pmem_load_we,
  output logic              load_ovf,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  // S_LDEND covers the cycle in which the final word is being written; the
  // core must not see FETCH until that write has landed. S_HALT is only
  // visible externally as present_state=LOAD with load_ready=0, halted=1.
  typedef enum logic [2:0] {
    S_LOAD,
    S_LDEND,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } seq_state_e;

  seq_state_e        state_q, state_d;
  cpu_state_e        present_state_q;
  logic              load_ready_q;
  logic              halted_q;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [ADDR_W-1:0] pmem_addr_q;
  logic [DATA_W-1:0] pmem_data_q;
  logic              pmem_we_q;
  logic              load_ovf_q;
  logic [CNT_W-1:0]  instr_count_q;
  logic              xfer;
  logic              at_top;
  logic              final_xfer;
`ifdef SINGLE_STEP_EN
  logic              step_run_q, step_run_d;
`endif

  // Map the internal state onto the 2-bit code the control unit decodes.
  function automatic cpu_state_e encode_state(input seq_state_e s);
    case (s)
      S_FETCH:  return ST_FETCH;
      S_DECODE: return ST_DECODE;
      S_EXEC:   return ST_EXECUTE;
      default:  return ST_LOAD;
    endcase
  endfunction

  // Handshake qualification and next-state selection.
  always_comb begin
    xfer       = ld.load_valid && load_ready_q;
    at_top     = (ld_addr_q == {ADDR_W{1'b1}});
    final_xfer = xfer && (ld.load_last || at_top);
    state_d    = state_q;
`ifdef SINGLE_STEP_EN
    step_run_d = step_run_q;
`endif
    case (state_q)
      S_LOAD:   if (final_xfer) state_d = S_LDEND;
      S_LDEND:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
`ifdef SINGLE_STEP_EN
        // A stepped instruction always returns to the parked state.
        step_run_d = 1'b0;
        state_d    = (halt || step_run_q) ? S_HALT : S_FETCH;
`else
        state_d    = halt ? S_HALT : S_FETCH;
`endif
      end
      S_HALT: begin
`ifdef SINGLE_STEP_EN
        if (step) begin
          state_d    = S_FETCH;
          step_run_d = 1'b1;
        end else if (!halt) begin
          state_d    = S_FETCH;
        end
`else
        if (!halt) state_d = S_FETCH;
`endif
      end
      default:  state_d = S_LOAD;
    endcase
  end

  // Sequencer state, load datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_LOAD;
      present_state_q <= ST_LOAD;
      load_ready_q    <= 1'b0;
      halted_q        <= 1'b0;
      ld_addr_q       <= '0;
      pmem_addr_q     <= '0;
      pmem_data_q     <= '0;
      pmem_we_q       <= 1'b0;
      load_ovf_q      <= 1'b0;
      instr_count_q   <= '0;
`ifdef SINGLE_STEP_EN
      step_run_q      <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      present_state_q <= encode_state(state_d);
      load_ready_q    <= (state_d == S_LOAD);
      halted_q        <= (state_d == S_HALT);
`ifdef SINGLE_STEP_EN
      step_run_q      <= step_run_d;
`endif
      // Write is issued the cycle after the transfer, at the pre-increment address.
      pmem_we_q <= xfer;
      if (xfer) begin
        pmem_addr_q <= ld_addr_q;
        pmem_data_q <= ld.load_data;
      end
      // The counter never wraps into FETCH: leaving LOAD clears it for the core.
      if (final_xfer) begin
        ld_addr_q <= '0;
      end else if (xfer) begin
        ld_addr_q <= ld_addr_q + ADDR_W'(1);
      end
      if (final_xfer && !ld.load_last) load_ovf_q <= 1'b1;
      // Every completed EXECUTE retires one instruction, halted or not.
      if (state_q == S_EXEC) instr_count_q <= instr_count_q + CNT_W'(1);
    end
  end

  assign ld.load_ready    = load_ready_q;
  assign present_state    = present_state_q;
  assign pmem_load_addr   = pmem_addr_q;
  assign pmem_load_data   = pmem_data_q;
  assign pmem_load_we     = pmem_we_q;
  assign load_ovf         = load_ovf_q;
  assign halted           = halted_q;
  assign instr_count      = instr_count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: one default-sized instance (A) and one with a
// 4-word memory and 3-bit counter (B) for overflow and count wrap.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        halt_a, halt_b;
`ifdef SINGLE_STEP_EN
  logic        step_a, step_b;
`endif
  logic [1:0]  st_a, st_b;
  logic [7:0]  addr_a;
  logic [1:0]  addr_b;
  logic [11:0] data_a, data_b;
  logic        we_a, we_b, ovf_a, ovf_b, hlt_a, hlt_b;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;

  int total = 0;
  int bad   = 0;
  int cnt_m [2];
  logic [11:0] prog [0:255];

  cpu_sequencer_if #(.DATA_W(12)) if_a ();
  cpu_sequencer_if #(.DATA_W(12)) if_b ();

  cpu_sequencer #(.ADDR_W(8), .DATA_W(12), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .ld(if_a.slave), .halt(halt_a),
`ifdef SINGLE_STEP_EN
    .step(step_a),
`endif
    .present_state(st_a), .pmem_load_addr(addr_a), .pmem_load_data(data_a),
    .pmem_load_we(we_a), .load_ovf(ovf_a), .halted(hlt_a), .instr_count(cnt_a)
  );

  cpu_sequencer #(.ADDR_W(2), .DATA_W(12), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ld(if_b.slave), .halt(halt_b),
`ifdef SINGLE_STEP_EN
    .step(step_b),
`endif
    .present_state(st_b), .pmem_load_addr(addr_b), .pmem_load_data(data_b),
    .pmem_load_we(we_b), .load_ovf(ovf_b), .halted(hlt_b), .instr_count(cnt_b)
  );

  function automatic int g_state(input bit b); return b ? int'(st_b) : int'(st_a); endfunction
  function automatic logic g_rdy(input bit b); return b ? if_b.load_ready : if_a.load_ready; endfunction
  function automatic logic g_we(input bit b); return b ? we_b : we_a; endfunction
  function automatic logic g_ovf(input bit b); return b ? ovf_b : ovf_a; endfunction
  function automatic logic g_hlt(input bit b); return b ? hlt_b : hlt_a; endfunction
  function automatic int g_addr(input bit b); return b ? int'(addr_b) : int'(addr_a); endfunction
  function automatic int g_data(input bit b); return b ? int'(data_b) : int'(data_a); endfunction
  function automatic int g_cnt(input bit b); return b ? int'(cnt_b) : int'(cnt_a); endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_load(input bit b, input logic v, input logic [11:0] d, input logic l);
    if (b) begin
      if_b.load_valid = v; if_b.load_data = d; if_b.load_last = l;
    end else begin
      if_a.load_valid = v; if_a.load_data = d; if_a.load_last = l;
    end
  endtask

  task automatic set_halt(input bit b, input logic h);
    if (b) halt_b = h; else halt_a = h;
  endtask

  // Holds reset for two cycles, releases it on a falling edge and returns at
  // the falling edge one rising edge later (first cycle with load_ready up).
  task automatic do_reset();
    rst_n = 1'b0;
    halt_a = 1'b0; halt_b = 1'b0;
`ifdef SINGLE_STEP_EN
    step_a = 1'b0; step_b = 1'b0;
`endif
    set_load(1'b0, 1'b0, 12'h0, 1'b0);
    set_load(1'b1, 1'b0, 12'h0, 1'b0);
    cnt_m[0] = 0; cnt_m[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Streams prog[0..n-1] with random valid gaps. Expected behaviour: ready high
  // until the final transfer, each word written one cycle after its transfer at
  // its stream index, FETCH appearing one cycle after the final write.
  task automatic load_prog(input bit b, input int n, input bit use_last);
    int depth = b ? 4 : 256;
    bit exp_rdy = 1'b1, prev_x = 1'b0, fin = 1'b0, xv;
    int prev_i = 0, sent = 0, post = 0, exp_st;
    for (int c = 0; c < 3000; c++) begin
      exp_st = (post >= 2) ? 1 : 0;
      total++;
      if (g_state(b) !== exp_st) begin
        bad++; $display("FAIL load_state dut%0d cyc%0d: got %0d want %0d", b, c, g_state(b), exp_st);
      end
      total++;
      if (g_rdy(b) !== exp_rdy) begin
        bad++; $display("FAIL load_ready dut%0d cyc%0d: got %0b want %0b", b, c, g_rdy(b), exp_rdy);
      end
      total++;
      if (g_we(b) !== prev_x) begin
        bad++; $display("FAIL load_we dut%0d cyc%0d: got %0b want %0b", b, c, g_we(b), prev_x);
      end
      if (prev_x) begin
        total++;
        if (g_addr(b) !== prev_i || g_data(b) !== int'(prog[prev_i])) begin
          bad++; $display("FAIL load_write dut%0d: got addr %0d data %0h want addr %0d data %0h",
                          b, g_addr(b), g_data(b), prev_i, prog[prev_i]);
        end
      end
      if (post == 2) break;
      xv = !fin && (sent < n) && ($urandom_range(0, 3) != 0);
      set_load(b, xv, prog[sent % 256], use_last && (sent == n - 1));
      prev_x = xv && exp_rdy;
      if (prev_x) begin
        prev_i = sent;
        if ((use_last && sent == n - 1) || sent == depth - 1) fin = 1'b1;
        sent++;
      end
      if (fin) begin
        exp_rdy = 1'b0;
        post++;
      end
      tick();
    end
    total++;
    if (post != 2) begin
      bad++; $display("FAIL load_timeout dut%0d: got post %0d want 2", b, post);
    end
    set_load(b, 1'b0, 12'h0, 1'b0);
  endtask

  // Random halt (and optionally junk load traffic) from a known FETCH cycle,
  // checked against the instruction-cycle rules; ends parked back at FETCH.
  task automatic run_random(input bit b, input int cycles, input int halt_pct,
                            input bit junk, input logic exp_ovf);
    int ps = 1, mask = b ? 7 : 65535;
    bit parked = 1'b0, h;
    bit done = 1'b0;
    for (int c = 0; c < cycles + 8; c++) begin
      total++;
      if (g_state(b) !== (parked ? 0 : ps) || g_hlt(b) !== parked) begin
        bad++; $display("FAIL run_state dut%0d cyc%0d: got st %0d hlt %0b want st %0d hlt %0b",
                        b, c, g_state(b), g_hlt(b), parked ? 0 : ps, parked);
      end
      total++;
      if (g_cnt(b) !== (cnt_m[b] & mask) || g_rdy(b) !== 1'b0) begin
        bad++; $display("FAIL run_count dut%0d cyc%0d: got cnt %0d rdy %0b want cnt %0d rdy 0",
                        b, c, g_cnt(b), g_rdy(b), cnt_m[b] & mask);
      end
      if (junk) begin
        total++;
        if (g_we(b) !== 1'b0 || g_ovf(b) !== exp_ovf) begin
          bad++; $display("FAIL run_ignore_load dut%0d: got we %0b ovf %0b want we 0 ovf %0b",
                          b, g_we(b), g_ovf(b), exp_ovf);
        end
        set_load(b, 1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)));
      end
      if (c >= cycles && !parked && ps == 1) begin
        done = 1'b1;
        break;
      end
      h = (c < cycles) && ($urandom_range(0, 99) < halt_pct);
      set_halt(b, h);
      if (parked) begin
        if (!h) begin parked = 1'b0; ps = 1; end
      end else if (ps == 3) begin
        cnt_m[b]++;
        if (h) parked = 1'b1; else ps = 1;
      end else begin
        ps++;
      end
      tick();
    end
    total++;
    if (!done) begin
      bad++; $display("FAIL run_timeout dut%0d: got parked %0b ps %0d want FETCH", b, parked, ps);
    end
    set_halt(b, 1'b0);
    set_load(b, 1'b0, 12'h0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (st_a !== 2'b00 || if_a.load_ready !== 1'b0 || addr_a !== 8'h0 || data_a !== 12'h0 ||
        we_a !== 1'b0 || ovf_a !== 1'b0 || hlt_a !== 1'b0 || cnt_a !== 16'h0) begin
      bad++; $display("FAIL reset_a: got st %0d rdy %0b addr %0h data %0h we %0b ovf %0b hlt %0b cnt %0d want all 0",
                      st_a, if_a.load_ready, addr_a, data_a, we_a, ovf_a, hlt_a, cnt_a);
    end
    total++;
    if (st_b !== 2'b00 || if_b.load_ready !== 1'b0 || we_b !== 1'b0 || ovf_b !== 1'b0 || cnt_b !== 3'h0) begin
      bad++; $display("FAIL reset_b: got st %0d rdy %0b we %0b ovf %0b cnt %0d want all 0",
                      st_b, if_b.load_ready, we_b, ovf_b, cnt_b);
    end
    do_reset();
    total++;
    if (if_a.load_ready !== 1'b1 || st_a !== 2'b00) begin
      bad++; $display("FAIL reset_release: got rdy %0b st %0d want rdy 1 st 0", if_a.load_ready, st_a);
    end
  endtask

  task automatic test_load_basic();
    prog[0] = 12'h8A1; prog[1] = 12'h123; prog[2] = 12'h0FF;
    load_prog(1'b0, 3, 1'b1);
    total++;
    if (ovf_a !== 1'b0) begin
      bad++; $display("FAIL load_basic_ovf: got %0b want 0", ovf_a);
    end
  endtask

  task automatic test_run5();
    for (int i = 0; i < 5; i++) begin
      for (int p = 1; p <= 3; p++) begin
        total++;
        if (st_a !== 2'(p) || cnt_a !== 16'(i)) begin
          bad++; $display("FAIL run5 instr%0d: got st %0d cnt %0d want st %0d cnt %0d", i, st_a, cnt_a, p, i);
        end
        tick();
      end
    end
    cnt_m[0] = 5;
    total++;
    if (st_a !== 2'b01 || cnt_a !== 16'd5) begin
      bad++; $display("FAIL run5_end: got st %0d cnt %0d want st 1 cnt 5", st_a, cnt_a);
    end
  endtask

  task automatic test_halt();
    tick();
    halt_a = 1'b1;
    total++;
    if (st_a !== 2'b10) begin bad++; $display("FAIL halt_decode: got %0d want 2", st_a); end
    tick();
    total++;
    if (st_a !== 2'b11 || hlt_a !== 1'b0) begin
      bad++; $display("FAIL halt_exec: got st %0d hlt %0b want st 3 hlt 0", st_a, hlt_a);
    end
    cnt_m[0]++;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (st_a !== 2'b00 || hlt_a !== 1'b1 || if_a.load_ready !== 1'b0 || cnt_a !== 16'(cnt_m[0])) begin
        bad++; $display("FAIL halt_parked%0d: got st %0d hlt %0b rdy %0b cnt %0d want st 0 hlt 1 rdy 0 cnt %0d",
                        k, st_a, hlt_a, if_a.load_ready, cnt_a, cnt_m[0]);
      end
    end
    halt_a = 1'b0;
    tick();
    total++;
    if (st_a !== 2'b01 || hlt_a !== 1'b0) begin
      bad++; $display("FAIL halt_release: got st %0d hlt %0b want st 1 hlt 0", st_a, hlt_a);
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    prog[0] = 12'hABC; prog[1] = 12'h456;
    set_load(1'b0, 1'b1, prog[0], 1'b0);
    tick();
    set_load(1'b0, 1'b1, prog[1], 1'b0);
    tick();
    set_load(1'b0, 1'b0, 12'h0, 1'b0);
    total++;
    if (we_a !== 1'b1 || addr_a !== 8'd1 || data_a !== 12'h456) begin
      bad++; $display("FAIL midload_write: got we %0b addr %0d data %0h want we 1 addr 1 data 456", we_a, addr_a, data_a);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (st_a !== 2'b00 || if_a.load_ready !== 1'b0 || addr_a !== 8'h0 || data_a !== 12'h0 ||
        we_a !== 1'b0 || ovf_a !== 1'b0 || hlt_a !== 1'b0 || cnt_a !== 16'h0) begin
      bad++; $display("FAIL midload_reset: got st %0d rdy %0b addr %0h data %0h we %0b cnt %0d want all 0",
                      st_a, if_a.load_ready, addr_a, data_a, we_a, cnt_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cnt_m[0] = 0;
    for (int i = 0; i < 20; i++) prog[i] = 12'($urandom);
    load_prog(1'b0, 20, 1'b1);
    total++;
    if (ovf_a !== 1'b0) begin bad++; $display("FAIL reload_ovf: got %0b want 0", ovf_a); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) prog[i] = 12'($urandom);
    load_prog(1'b1, 4, 1'b0);
    total++;
    if (ovf_b !== 1'b1) begin bad++; $display("FAIL ovf_set: got %0b want 1", ovf_b); end
    // Extra words after the load phase must be dropped; the 3-bit count wraps.
    run_random(1'b1, 80, 25, 1'b1, 1'b1);
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_step();
    do_reset();
    prog[0] = 12'h111; prog[1] = 12'h222;
    load_prog(1'b0, 2, 1'b1);
    halt_a = 1'b1;
    tick(); tick(); tick();
    cnt_m[0] = 1;
    total++;
    if (st_a !== 2'b00 || hlt_a !== 1'b1 || cnt_a !== 16'd1) begin
      bad++; $display("FAIL step_park: got st %0d hlt %0b cnt %0d want st 0 hlt 1 cnt 1", st_a, hlt_a, cnt_a);
    end
    step_a = 1'b1;
    tick();
    step_a = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      total++;
      if (st_a !== 2'(p) || hlt_a !== 1'b0) begin
        bad++; $display("FAIL step_seq: got st %0d hlt %0b want st %0d hlt 0", st_a, hlt_a, p);
      end
      if (p == 2) step_a = 1'b1;
      tick();
      step_a = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (st_a !== 2'b00 || hlt_a !== 1'b1 || cnt_a !== 16'd2) begin
        bad++; $display("FAIL step_return%0d: got st %0d hlt %0b cnt %0d want st 0 hlt 1 cnt 2",
                        k, st_a, hlt_a, cnt_a);
      end
      tick();
    end
    halt_a = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    halt_a = 1'b0; halt_b = 1'b0;
`ifdef SINGLE_STEP_EN
    step_a = 1'b0; step_b = 1'b0;
`endif
    set_load(1'b0, 1'b0, 12'h0, 1'b0);
    set_load(1'b1, 1'b0, 12'h0, 1'b0);
    cnt_m[0] = 0; cnt_m[1] = 0;
    @(negedge clk);
    test_reset();
    test_load_basic();
    test_run5();
    test_halt();
    run_random(1'b0, 200, 20, 1'b1, 1'b0);
    test_reset_midload();
    run_random(1'b0, 60, 40, 1'b0, 1'b0);
    test_overflow();
`ifdef SINGLE_STEP_EN
    test_step();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
